// File: rtl/mem_arbiter.sv
// Arbitrates a shared memory port between instruction and data caches.
// Data wins ties, but a pending instruction request is served after STARVE data grants.
module mem_arbiter #(
   parameter int STARVE = 4
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] i_a,
   input  logic        i_strobe,
   output logic [31:0] i_dout,
   output logic        i_ready,
   input  logic [31:0] d_a,
   input  logic [31:0] d_din,
   input  logic        d_rw,
   input  logic        d_strobe,
   output logic [31:0] d_dout,
   output logic        d_ready,
   output logic [31:0] m_a,
   output logic [31:0] m_din,
   output logic        m_rw,
   output logic        m_strobe,
   input  logic [31:0] m_dout,
   input  logic        m_ready
);

   localparam logic [7:0] STARVE_C = 8'(STARVE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_strobe && d_strobe) begin
               state_d = (starve_cnt_q >= STARVE_C) ? IBUSY : DBUSY;
            end else if (i_strobe) begin
               state_d = IBUSY;
            end else if (d_strobe) begin
               state_d = DBUSY;
            end
            // Only data grants that bypass a waiting instruction request count toward starvation.
            if (!i_strobe || state_d == IBUSY) begin
               starve_cnt_d = 8'd0;
            end else if (state_d == DBUSY && starve_cnt_q != 8'hFF) begin
               starve_cnt_d = starve_cnt_q + 8'd1;
            end
         end
         IBUSY, DBUSY: begin
            if (m_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= IDLE;
         starve_cnt_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign m_strobe = (state_q == IBUSY) || (state_q == DBUSY);
   assign m_a      = (state_q == IBUSY) ? i_a : ((state_q == DBUSY) ? d_a : 32'd0);
   assign m_rw     = (state_q == DBUSY) ? d_rw : 1'b0;
   assign m_din    = d_din;
   assign i_ready  = (state_q == IBUSY) && m_ready;
   assign d_ready  = (state_q == DBUSY) && m_ready;
   assign i_dout   = m_dout;
   assign d_dout   = m_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change and outputs are
// checked shortly after each falling clock edge, away from the active edge.
module tb_mem_arbiter;

   logic        clk;
   logic        clrn;
   logic [31:0] i_a;
   logic        i_strobe;
   logic [31:0] i_dout;
   logic        i_ready;
   logic [31:0] d_a;
   logic [31:0] d_din;
   logic        d_rw;
   logic        d_strobe;
   logic [31:0] d_dout;
   logic        d_ready;
   logic [31:0] m_a;
   logic [31:0] m_din;
   logic        m_rw;
   logic        m_strobe;
   logic [31:0] m_dout;
   logic        m_ready;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.STARVE(4)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .i_a      (i_a),
      .i_strobe (i_strobe),
      .i_dout   (i_dout),
      .i_ready  (i_ready),
      .d_a      (d_a),
      .d_din    (d_din),
      .d_rw     (d_rw),
      .d_strobe (d_strobe),
      .d_dout   (d_dout),
      .d_ready  (d_ready),
      .m_a      (m_a),
      .m_din    (m_din),
      .m_rw     (m_rw),
      .m_strobe (m_strobe),
      .m_dout   (m_dout),
      .m_ready  (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      clrn = 1'b0; i_a = 32'h0000_0A00; i_strobe = 1'b1; d_a = 32'd0; d_din = 32'd0;
      d_rw = 1'b1; d_strobe = 1'b1; m_dout = 32'd0; m_ready = 1'b1;
      #2;
      checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_strobe: got %b expected 0", m_strobe); end
      checks++; if (m_a !== 32'd0 || m_rw !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_a_rw: got %h/%b expected 0/0", m_a, m_rw); end
      @(negedge clk); #1;
      checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || m_strobe !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_held: got i_ready=%b d_ready=%b m_strobe=%b expected 0/0/0", i_ready, d_ready, m_strobe);
      end
      d_strobe = 1'b0; d_rw = 1'b0; m_ready = 1'b0;
      @(negedge clk); clrn = 1'b1; #1;
      checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_idle: got %b expected 0", m_strobe); end
      @(negedge clk); #1;
      checks++; if (m_strobe !== 1'b1 || m_a !== 32'h0000_0A00) begin
         errors++; $display("[TB] FAIL first_grant: got m_strobe=%b m_a=%h expected 1/00000a00", m_strobe, m_a);
      end
      m_ready = 1'b1; #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_grant_ready: got %b expected 1", i_ready); end
      @(negedge clk); i_strobe = 1'b0; m_ready = 1'b0; #1;
      checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL first_grant_idle: got %b expected 0", m_strobe); end
   endtask

   task automatic test_single_read();
      @(negedge clk);
      i_a = 32'h0000_0100; i_strobe = 1'b1; m_ready = 1'b0; m_dout = 32'hFFFF_0000; #1;
      checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle: got %b expected 0", m_strobe); end
      for (int w = 1; w <= 3; w++) begin
         @(negedge clk); #1;
         checks++; if (m_strobe !== 1'b1 || m_a !== 32'h0000_0100 || m_rw !== 1'b0 || i_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_wait%0d: got strobe=%b a=%h rw=%b ready=%b expected 1/00000100/0/0", w, m_strobe, m_a, m_rw, i_ready);
         end
      end
      @(negedge clk); m_ready = 1'b1; m_dout = 32'h1234_5678; #1;
      checks++; if (i_ready !== 1'b1 || i_dout !== 32'h1234_5678 || d_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL rd_done: got i_ready=%b i_dout=%h d_ready=%b expected 1/12345678/0", i_ready, i_dout, d_ready);
      end
      @(negedge clk); i_strobe = 1'b0; m_ready = 1'b0; #1;
      checks++; if (i_ready !== 1'b0 || m_strobe !== 1'b0) begin
         errors++; $display("[TB] FAIL rd_after: got i_ready=%b m_strobe=%b expected 0/0", i_ready, m_strobe);
      end
   endtask

   task automatic test_starvation();
      logic exp_i;
      @(negedge clk);
      i_a = 32'h0000_0100; d_a = 32'h0000_0200; d_rw = 1'b0;
      i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk); #1;
         if (n % 2 == 1) begin
            exp_i = (((n - 1) / 2) % 5 == 4);
            checks++; if (i_ready !== exp_i || d_ready !== !exp_i) begin
               errors++; $display("[TB] FAIL starve_grant%0d: got i_ready=%b d_ready=%b expected %b/%b", (n - 1) / 2, i_ready, d_ready, exp_i, !exp_i);
            end
            checks++; if (m_a !== (exp_i ? 32'h0000_0100 : 32'h0000_0200)) begin
               errors++; $display("[TB] FAIL starve_addr%0d: got %h expected %h", (n - 1) / 2, m_a, exp_i ? 32'h0000_0100 : 32'h0000_0200);
            end
         end else begin
            checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL starve_idle%0d: got %b expected 0", n, m_strobe); end
         end
      end
      i_strobe = 1'b0; d_strobe = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_write();
      @(negedge clk);
      d_rw = 1'b1; d_a = 32'h0000_0040; d_din = 32'hDEAD_BEEF; d_strobe = 1'b1; m_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if (m_strobe !== 1'b1 || m_rw !== 1'b1 || m_a !== 32'h0000_0040 || m_din !== 32'hDEAD_BEEF || d_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL wr_busy: got strobe=%b rw=%b a=%h din=%h ready=%b expected 1/1/00000040/deadbeef/0", m_strobe, m_rw, m_a, m_din, d_ready);
      end
      @(negedge clk); m_ready = 1'b1; #1;
      checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL wr_done: got d_ready=%b i_ready=%b expected 1/0", d_ready, i_ready);
      end
      @(negedge clk); d_strobe = 1'b0; m_ready = 1'b0; #1;
      checks++; if (m_strobe !== 1'b0 || m_rw !== 1'b0) begin
         errors++; $display("[TB] FAIL wr_idle: got m_strobe=%b m_rw=%b expected 0/0", m_strobe, m_rw);
      end
      d_rw = 1'b0;
   endtask

   task automatic test_grant_lock();
      @(negedge clk);
      i_a = 32'h0000_0300; d_a = 32'h0000_0500; i_strobe = 1'b1; m_ready = 1'b0;
      @(negedge clk); d_strobe = 1'b1; #1;
      checks++; if (m_a !== 32'h0000_0300) begin errors++; $display("[TB] FAIL lock_a1: got %h expected 00000300", m_a); end
      @(negedge clk); #1;
      checks++; if (m_a !== 32'h0000_0300 || d_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL lock_a2: got m_a=%h d_ready=%b expected 00000300/0", m_a, d_ready);
      end
      @(negedge clk); m_ready = 1'b1; #1;
      checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0 || m_a !== 32'h0000_0300) begin
         errors++; $display("[TB] FAIL lock_done: got i_ready=%b d_ready=%b m_a=%h expected 1/0/00000300", i_ready, d_ready, m_a);
      end
      @(negedge clk); i_strobe = 1'b0; m_ready = 1'b0; #1;
      checks++; if (m_strobe !== 1'b0) begin errors++; $display("[TB] FAIL lock_idle: got %b expected 0", m_strobe); end
      @(negedge clk); #1;
      checks++; if (m_strobe !== 1'b1 || m_a !== 32'h0000_0500) begin
         errors++; $display("[TB] FAIL lock_dgrant: got m_strobe=%b m_a=%h expected 1/00000500", m_strobe, m_a);
      end
      @(negedge clk); m_ready = 1'b1; #1;
      checks++; if (d_ready !== 1'b1) begin errors++; $display("[TB] FAIL lock_ddone: got %b expected 1", d_ready); end
      @(negedge clk); d_strobe = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      logic exp_i;
      @(negedge clk);
      i_a = 32'h0000_0700; d_a = 32'h0000_0600; i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b1;
      for (int n = 1; n <= 4; n++) @(negedge clk);
      m_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if (m_strobe !== 1'b1 || m_a !== 32'h0000_0600) begin
         errors++; $display("[TB] FAIL mid_busy: got m_strobe=%b m_a=%h expected 1/00000600", m_strobe, m_a);
      end
      #1; clrn = 1'b0; m_ready = 1'b1; #1;
      checks++; if (m_strobe !== 1'b0 || d_ready !== 1'b0 || i_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_abort: got m_strobe=%b d_ready=%b i_ready=%b expected 0/0/0", m_strobe, d_ready, i_ready);
      end
      @(negedge clk); clrn = 1'b1;
      // A cleared starvation counter means four data grants again precede the instruction grant.
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
         if (k % 2 == 1) begin
            exp_i = ((k - 1) / 2 == 4);
            checks++; if (i_ready !== exp_i || d_ready !== !exp_i) begin
               errors++; $display("[TB] FAIL mid_regrant%0d: got i_ready=%b d_ready=%b expected %b/%b", (k - 1) / 2, i_ready, d_ready, exp_i, !exp_i);
            end
         end
      end
      i_strobe = 1'b0; d_strobe = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_zero_wait();
      logic prev_ready;
      @(negedge clk);
      i_a = 32'h0000_0800; i_strobe = 1'b1; m_ready = 1'b1;
      prev_ready = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk); #1;
         checks++; if (i_ready !== (n % 2 == 1) || (prev_ready && i_ready)) begin
            errors++; $display("[TB] FAIL zw_cycle%0d: got i_ready=%b expected %b", n, i_ready, (n % 2 == 1));
         end
         prev_ready = i_ready;
      end
      i_strobe = 1'b0; m_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_starvation();
      test_write();
      test_grant_lock();
      test_reset_mid_op();
      test_zero_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE, default 4, maximum number of consecutive data-side grants issued while an instruction request is pending (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset; asynchronous, active-low.
REQ-004 i_a  input  32  instruction-cache miss address.
REQ-005 i_strobe  input  1  instruction-cache read request; level, held until i_ready.
REQ-006 i_dout  output  32  read data to instruction cache.
REQ-007 i_ready  output  1  instruction request complete.
REQ-008 d_a  input  32  data-cache address.
REQ-009 d_din  input  32  data-cache write data.
REQ-010 d_rw  input  1  data-side direction: 1 write, 0 read.
REQ-011 d_strobe  input  1  data-cache request; level, held until d_ready.
REQ-012 d_dout  output  32  read data to data cache.
REQ-013 d_ready  output  1  data request complete.
REQ-014 m_a  output  32  memory address.
REQ-015 m_din  output  32  memory write data.
REQ-016 m_rw  output  1  memory direction: 1 write.
REQ-017 m_strobe  output  1  memory request.
REQ-018 m_dout  input  32  memory read data.
REQ-019 m_ready  input  1  memory completion, one-cycle pulse or level; sampled only while m_strobe=1.

Function
REQ-020 FSM states: IDLE, IBUSY, DBUSY, held in a registered state variable.
REQ-021 IDLE, no strobe: stay IDLE.
REQ-022 IDLE, only i_strobe: next IBUSY; only d_strobe: next DBUSY.
REQ-023 IDLE, both strobes: next IBUSY if starve_cnt >= STARVE, else DBUSY.
REQ-024 IBUSY/DBUSY: hold until m_ready=1, then next IDLE; exactly one IDLE cycle between grants, so no stale re-grant occurs.
REQ-025 Grant is locked for the whole transaction; strobe changes on either side during IBUSY/DBUSY are ignored.
REQ-026 m_strobe = 1 iff state is IBUSY or DBUSY; combinational from state.
REQ-027 m_a = i_a in IBUSY, d_a in DBUSY, 0 in IDLE.
REQ-028 m_rw = d_rw in DBUSY, else 0; m_din = d_din in all states.
REQ-029 i_ready = (state==IBUSY) & m_ready; d_ready = (state==DBUSY) & m_ready; combinational, same cycle as m_ready.
REQ-030 i_dout = m_dout and d_dout = m_dout, combinational pass-through; valid only in the ready cycle.
REQ-031 Grant-to-memory latency: m_strobe asserts the cycle after the granting IDLE cycle; minimum request-to-ready is 2 cycles with m_ready tied high.
REQ-032 starve_cnt: 8-bit register.
  - On each IDLE->DBUSY transition with i_strobe=1: increment, saturating at 255.
  - On each IDLE->IBUSY transition: clear to 0.
  - In IDLE with i_strobe=0: clear to 0.
REQ-033 Write transactions (m_rw=1) complete on m_ready exactly like reads; d_dout content is don't-care on writes.
REQ-034 A requester dropping its strobe before its grant is legal and causes no transaction.

Reset
REQ-035 clrn low: state=IDLE and starve_cnt=0 immediately, independent of clk.
REQ-036 During and after reset: m_strobe=0, m_rw=0, m_a=0, i_ready=0, d_ready=0.
REQ-037 Reset mid-transaction abandons the transaction; no ready is issued for it, and the requester re-arbitrates after release.
REQ-038 First grant is possible on the first rising edge after clrn deasserts.

Verification
REQ-039 Single I read: i_a=0x0000_0100, i_strobe=1, memory gives 3 wait cycles, m_dout=0x1234_5678 -> m_a=0x100, m_rw=0, one-cycle i_ready with i_dout=0x1234_5678, d_ready stays 0.
REQ-040 Simultaneous requests, STARVE=4: i_strobe and d_strobe held high, d_a=0x200 -> first grant DBUSY; I is granted only after the 4th consecutive D grant; starve_cnt then returns to 0.
REQ-041 D write: d_rw=1, d_a=0x0000_0040, d_din=0xDEAD_BEEF -> m_rw=1, m_din=0xDEAD_BEEF, d_ready on the m_ready cycle, followed by one IDLE cycle with m_strobe=0.
REQ-042 Grant lock: in IBUSY, d_strobe rises -> m_a stays i_a until m_ready; DBUSY entered only after the IDLE cycle.
REQ-043 Reset mid-op: clrn pulsed low during DBUSY before m_ready -> m_strobe=0 in the same cycle, no d_ready, starve_cnt=0; a held d_strobe is re-granted after release.
REQ-044 Zero-wait memory: m_ready tied 1, i_strobe held -> i_ready every second cycle, never two consecutive cycles.
